ym3438_out_mixer: RTL and testbench
===================================

# ym3438_out_mixer

Downstream stage of the OPN2 core. Consumes the time-multiplexed per-slot MOL/MOR outputs and sums one full sample frame per side. Emits signed 16-bit stereo PCM words through a 2-entry valid/ready buffer for a host DAC, I2S or resampler path. Also tracks frame alignment and reports sync and overflow errors.

## Interface
Parameters:
- SLOTS, 24: PHI samples per frame (6 channels x 4 slots); legal range 2..32.
- GAIN, 0: left shift applied to each frame sum before saturation; legal range 0..4.

Ports:
- MCLK  in  1  master clock; all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- phi_en  in  1  one-MCLK strobe; MOL/MOR hold one new slot sample in this cycle.
- frame_sync  in  1  qualified by phi_en; marks the first slot of a frame (fsm_sel23-derived).
- MOL, MOR  in  9  per-slot channel output, offset binary; value = code - 256, so 9'h100 = 0.
- out_l, out_r  out  16  signed PCM at FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head when out_valid & out_ready.
- locked  out  1  frame alignment established.
- sync_err  out  1  sticky; set on alignment violation.
- overflow  out  1  sticky; set when a completed frame is dropped because FIFO full.
- clr_flags  in  1  clears sync_err and overflow; a same-cycle set event wins.

## Operation
- Sample conversion: s = {~code[8], code[7:0]} as 9-bit signed, range -256..255.
- Accumulators acc_l, acc_r: 14-bit signed (24 x 9-bit bound -6144..6120). The first slot of a frame loads s. Later slots add s.
- Slot counter: 5-bit, counts accepted phi_en samples within a frame, 0..SLOTS-1.
- FSM states:
  - UNLOCKED, reset state: ignore samples until phi_en & frame_sync. On that sample load acc, set slot=1, go LOCKED.
  - LOCKED, normal slot (phi_en, slot 1..SLOTS-1, frame_sync=0): accumulate, slot++.
  - LOCKED, last slot (slot==SLOTS-1): the accumulation completes the frame. Assert the internal done pulse next cycle. slot wraps to 0.
  - LOCKED, slot==0 with frame_sync=1: load acc, slot=1.
  - Violation: frame_sync=1 at slot!=0, or frame_sync=0 at slot==0. Set sync_err and discard the partial frame.
    - If frame_sync=1, restart: this sample is slot 0 and the FSM stays LOCKED.
    - Otherwise go UNLOCKED.
- locked = (state==LOCKED).
- Output scaling: w = acc << GAIN, sign-extended. Saturate to [-32768, 32767] per side independently.
- FIFO: 2 entries of {l,r}.
  - On done: push if not full, else drop the frame and set overflow.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle are both honoured, including when full: the pop frees space first, so no overflow.
- reset mid-frame: acc, slot, FIFO, flags and state are cleared, and the FSM enters UNLOCKED. There is no partial output.

## Timing
- Reset values: out_l=0, out_r=0, out_valid=0, locked=0, sync_err=0, overflow=0.
- Last-slot phi_en sampled at edge k: acc final at edge k. Saturated word written to FIFO at edge k+1. out_valid=1 after edge k+1 if the FIFO was empty. Latency is 2 MCLK.
- out_l/out_r are registered FIFO head outputs; they hold stable while out_valid & ~out_ready.
- phi_en may be asserted on consecutive MCLK cycles. The minimum frame is SLOTS MCLK.
- frame_sync without phi_en is ignored.
- locked rises after the edge that samples the first phi_en & frame_sync.
- locked falls after the edge that samples an unrecoverable violation.

## Test plan
- Silence, full PCM path: reset, then 3 aligned frames of MOL=MOR=9'h100 (frame_sync on slot 0), out_ready=1 -> 3 words l=r=0. out_valid rises 2 MCLK after each last slot. locked=1, no flags.
- Max positive with GAIN=2: MOL=9'h1FF, MOR=9'h100, all 24 slots -> out_l=24480, out_r=0.
- Saturation with GAIN=3: MOL=9'h000, MOR=9'h1FF -> out_l=-32768 (raw -49152), out_r=32767 (raw 48960).
- Backpressure: out_ready=0 for 3 frames -> first 2 words retained in order, third dropped, overflow=1.
  - Then out_ready=1 with a frame completing the same cycle as a pop -> no new overflow.
  - clr_flags -> overflow=0.
- Misalignment, restart: frame_sync at slot 10 -> sync_err=1, locked stays 1, partial frame discarded, next word sums slots from the resync point.
- Misalignment, unlock: frame_sync=0 at slot 0 -> sync_err=1, locked=0 until the next frame_sync.
- Mid-frame reset: reset asserted at slot 12 -> all outputs at reset values next cycle, and no word is emitted for the interrupted frame.

Source files
------------

// File: rtl/ym3438_out_mixer.sv
// rtl/ym3438_out_mixer.sv - OPN2 per-slot MOL/MOR frame summer with 2-entry stereo PCM output buffer
//
// Sums one frame of SLOTS offset-binary slot samples per side, scales by
// 2^GAIN, saturates to signed 16-bit and queues {l,r} words for a consumer.
//
// Ports:
//   MCLK        master clock, all state on rising edge
//   reset       synchronous active-high clear
//   phi_en      one-cycle strobe, MOL/MOR carry a new slot sample
//   frame_sync  qualified by phi_en, marks slot 0 of a frame
//   MOL, MOR    9-bit offset-binary slot outputs (9'h100 = 0)
//   out_l/out_r signed PCM at buffer head (registered)
//   out_valid   buffer non-empty
//   out_ready   consumer accepts head when out_valid & out_ready
//   locked      frame alignment established
//   sync_err    sticky alignment violation flag
//   overflow    sticky dropped-frame flag
//   clr_flags   clears sticky flags; a same-cycle set wins

module ym3438_out_mixer #(
  parameter int SLOTS = 24,
  parameter int GAIN  = 0
) (
  input  logic               MCLK,
  input  logic               reset,
  input  logic               phi_en,
  input  logic               frame_sync,
  input  logic [8:0]         MOL,
  input  logic [8:0]         MOR,
  output logic signed [15:0] out_l,
  output logic signed [15:0] out_r,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               locked,
  output logic               sync_err,
  output logic               overflow,
  input  logic               clr_flags
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  localparam logic [4:0] LAST_SLOT = 5'(SLOTS - 1);

  state_t             state_q, state_d;
  logic [4:0]         slot_q, slot_d;
  logic signed [13:0] acc_l_q, acc_l_d;
  logic signed [13:0] acc_r_q, acc_r_d;
  logic               done_q, done_d;
  logic               sync_set;
  logic               sync_err_q, sync_err_d;
  logic               overflow_q, overflow_d;
  logic [31:0]        head_q, head_d;
  logic [31:0]        tail_q, tail_d;
  logic               head_v_q, head_v_d;
  logic               tail_v_q, tail_v_d;

  logic signed [13:0] s_l, s_r;
  logic [31:0]        word;
  logic               full, pop, push, drop;

  // Offset binary to two's complement: flip the MSB, then sign-extend.
  assign s_l = {{6{~MOL[8]}}, MOL[7:0]};
  assign s_r = {{6{~MOR[8]}}, MOR[7:0]};

  function automatic logic [15:0] sat16(input logic signed [13:0] acc);
    logic signed [19:0] w;
    w = {{6{acc[13]}}, acc} <<< GAIN;
    if (w > 20'sd32767) begin
      return 16'h7FFF;
    end else if (w < -20'sd32768) begin
      return 16'h8000;
    end else begin
      return w[15:0];
    end
  endfunction

  // acc_*_q is final during the cycle done_q is high.
  assign word = {sat16(acc_l_q), sat16(acc_r_q)};

  // Frame alignment FSM and accumulators
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    acc_l_d  = acc_l_q;
    acc_r_d  = acc_r_q;
    done_d   = 1'b0;
    sync_set = 1'b0;
    if (phi_en) begin
      case (state_q)
        ST_UNLOCKED: begin
          if (frame_sync) begin
            acc_l_d = s_l;
            acc_r_d = s_r;
            slot_d  = 5'd1;
            state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (slot_q == 5'd0) begin
            if (frame_sync) begin
              acc_l_d = s_l;
              acc_r_d = s_r;
              slot_d  = 5'd1;
            end else begin
              // Missing frame start: no way to realign without a marker.
              sync_set = 1'b1;
              slot_d   = 5'd0;
              state_d  = ST_UNLOCKED;
            end
          end else if (frame_sync) begin
            // Early frame start: drop the partial frame and restart here.
            sync_set = 1'b1;
            acc_l_d  = s_l;
            acc_r_d  = s_r;
            slot_d   = 5'd1;
          end else begin
            acc_l_d = acc_l_q + s_l;
            acc_r_d = acc_r_q + s_r;
            if (slot_q == LAST_SLOT) begin
              slot_d = 5'd0;
              done_d = 1'b1;
            end else begin
              slot_d = slot_q + 5'd1;
            end
          end
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end
  end

  // Two-entry output buffer; a pop frees space for a same-cycle push.
  assign full = head_v_q & tail_v_q;
  assign pop  = head_v_q & out_ready;
  assign push = done_q & (~full | pop);
  assign drop = done_q & full & ~pop;

  always_comb begin
    head_d   = head_q;
    head_v_d = head_v_q;
    tail_d   = tail_q;
    tail_v_d = tail_v_q;
    if (pop) begin
      head_d   = tail_q;
      head_v_d = tail_v_q;
      tail_v_d = 1'b0;
    end
    if (push) begin
      if (!head_v_d) begin
        head_d   = word;
        head_v_d = 1'b1;
      end else begin
        tail_d   = word;
        tail_v_d = 1'b1;
      end
    end
  end

  assign sync_err_d = sync_set | (sync_err_q & ~clr_flags);
  assign overflow_d = drop | (overflow_q & ~clr_flags);

  always_ff @(posedge MCLK) begin
    if (reset) begin
      state_q    <= ST_UNLOCKED;
      slot_q     <= 5'd0;
      acc_l_q    <= '0;
      acc_r_q    <= '0;
      done_q     <= 1'b0;
      sync_err_q <= 1'b0;
      overflow_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      head_v_q   <= 1'b0;
      tail_v_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      acc_l_q    <= acc_l_d;
      acc_r_q    <= acc_r_d;
      done_q     <= done_d;
      sync_err_q <= sync_err_d;
      overflow_q <= overflow_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      head_v_q   <= head_v_d;
      tail_v_q   <= tail_v_d;
    end
  end

  assign out_l     = head_q[31:16];
  assign out_r     = head_q[15:0];
  assign out_valid = head_v_q;
  assign locked    = (state_q == ST_LOCKED);
  assign sync_err  = sync_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ym3438_out_mixer.sv
// tb/tb_ym3438_out_mixer.sv - scoreboard bench for ym3438_out_mixer at GAIN 0, 2 and 3

module tb_ym3438_out_mixer;

  logic clk = 1'b0;
  logic rst, phi_en, frame_sync, out_ready, clr_flags;
  logic [8:0] mol, mor;

  logic signed [15:0] l0, r0, l2, r2, l3, r3;
  logic v0, v2, v3, lk0, lk2, lk3, se0, se2, se3, ov0, ov2, ov3;

  int checks = 0;
  int errors = 0;

  logic [31:0] q0[$];
  logic [31:0] q2[$];
  logic [31:0] q3[$];

  always #5 clk = ~clk;

  ym3438_out_mixer #(.SLOTS(24), .GAIN(0)) g0 (
    .MCLK(clk), .reset(rst), .phi_en(phi_en), .frame_sync(frame_sync),
    .MOL(mol), .MOR(mor), .out_l(l0), .out_r(r0), .out_valid(v0),
    .out_ready(out_ready), .locked(lk0), .sync_err(se0), .overflow(ov0),
    .clr_flags(clr_flags));

  ym3438_out_mixer #(.SLOTS(24), .GAIN(2)) g2 (
    .MCLK(clk), .reset(rst), .phi_en(phi_en), .frame_sync(frame_sync),
    .MOL(mol), .MOR(mor), .out_l(l2), .out_r(r2), .out_valid(v2),
    .out_ready(out_ready), .locked(lk2), .sync_err(se2), .overflow(ov2),
    .clr_flags(clr_flags));

  ym3438_out_mixer #(.SLOTS(24), .GAIN(3)) g3 (
    .MCLK(clk), .reset(rst), .phi_en(phi_en), .frame_sync(frame_sync),
    .MOL(mol), .MOR(mor), .out_l(l3), .out_r(r3), .out_valid(v3),
    .out_ready(out_ready), .locked(lk3), .sync_err(se3), .overflow(ov3),
    .clr_flags(clr_flags));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int sv(input logic [8:0] c);
    return int'(c) - 256;
  endfunction

  function automatic logic [15:0] bsat(input int v, input int g);
    int w;
    w = v * (1 << g);
    if (w > 32767) w = 32767;
    if (w < -32768) w = -32768;
    return w[15:0];
  endfunction

  task automatic push_exp(input int sl, input int sr);
    q0.push_back({bsat(sl, 0), bsat(sr, 0)});
    q2.push_back({bsat(sl, 2), bsat(sr, 2)});
    q3.push_back({bsat(sl, 3), bsat(sr, 3)});
  endtask

  task automatic send(input logic [8:0] l, input logic [8:0] r, input logic fs);
    @(posedge clk); #1;
    phi_en = 1'b1; frame_sync = fs; mol = l; mor = r;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      phi_en = 1'b0; frame_sync = 1'b0;
    end
  endtask

  // One aligned frame of constant codes; gaps inserts idle cycles carrying
  // an unqualified frame_sync between samples.
  task automatic frame(input logic [8:0] l, input logic [8:0] r, input bit gaps, input bit keep);
    if (keep) push_exp(24 * sv(l), 24 * sv(r));
    send(l, r, 1'b1);
    for (int i = 1; i < 24; i++) begin
      if (gaps) begin
        @(posedge clk); #1;
        phi_en = 1'b0; frame_sync = 1'b1;
      end
      send(l, r, 1'b0);
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; clr_flags = 1'b1; phi_en = 1'b0; frame_sync = 1'b0;
    @(posedge clk); #1; clr_flags = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_l0"}, l0, 0);   chk({tag, "_r0"}, r0, 0);
    chk({tag, "_l2"}, l2, 0);   chk({tag, "_r2"}, r2, 0);
    chk({tag, "_l3"}, l3, 0);   chk({tag, "_r3"}, r3, 0);
    chk({tag, "_v"}, {v0, v2, v3}, 0);
    chk({tag, "_lk"}, {lk0, lk2, lk3}, 0);
    chk({tag, "_se"}, {se0, se2, se3}, 0);
    chk({tag, "_ov"}, {ov0, ov2, ov3}, 0);
  endtask

  // Monitor: every accepted word must match the oldest expectation.
  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (!rst) begin
      if (v0 && out_ready) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL g0_word actual=%0d,%0d required=none", l0, r0);
        end else begin
          e = q0.pop_front();
          chk("g0_l", l0, $signed(e[31:16]));
          chk("g0_r", r0, $signed(e[15:0]));
        end
      end
      if (v2 && out_ready) begin
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL g2_word actual=%0d,%0d required=none", l2, r2);
        end else begin
          e = q2.pop_front();
          chk("g2_l", l2, $signed(e[31:16]));
          chk("g2_r", r2, $signed(e[15:0]));
        end
      end
      if (v3 && out_ready) begin
        if (q3.size() == 0) begin
          checks++; errors++;
          $display("FAIL g3_word actual=%0d,%0d required=none", l3, r3);
        end else begin
          e = q3.pop_front();
          chk("g3_l", l3, $signed(e[31:16]));
          chk("g3_r", r3, $signed(e[15:0]));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; phi_en = 1'b0; frame_sync = 1'b0; out_ready = 1'b1;
    clr_flags = 1'b0; mol = 9'h100; mor = 9'h100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    @(posedge clk); #1; rst = 1'b0;

    // Silence, with 2-cycle latency from last slot to out_valid
    for (int f = 0; f < 3; f++) begin
      frame(9'h100, 9'h100, 1'b0, 1'b1);
      @(posedge clk); #1; phi_en = 1'b0;
      @(negedge clk); chk("lat_k_valid", v0, 0);
      @(negedge clk); chk("lat_k1_valid", v0, 1);
    end
    chk("sil_locked", lk0, 1);
    chk("sil_flags", {se0, ov0}, 0);

    // Max positive left, zero right
    frame(9'h1FF, 9'h100, 1'b0, 1'b1);
    idle(3);

    // Negative full scale / positive full scale, gapped with stray frame_sync
    frame(9'h000, 9'h1FF, 1'b1, 1'b1);
    idle(3);
    chk("gap_sync_err", {se0, se2, se3}, 0);

    // Backpressure: two words held, third dropped
    out_ready = 1'b0;
    frame(9'h180, 9'h0C0, 1'b0, 1'b1); idle(2);
    frame(9'h0C0, 9'h180, 1'b0, 1'b1); idle(2);
    frame(9'h1FF, 9'h1FF, 1'b0, 1'b0); idle(3);
    @(negedge clk);
    chk("bp_overflow", {ov0, ov2, ov3}, 3'b111);
    chk("bp_valid", v0, 1);
    chk("bp_head_g0", l0, 3072);
    chk("bp_head_g2", l2, 12288);
    chk("bp_head_g3", l3, 24576);
    pulse_clr();
    @(negedge clk);
    chk("clr_overflow", {ov0, ov2, ov3}, 0);
    // Frame completes into a full buffer in the cycle that pops the head
    frame(9'h100, 9'h1FF, 1'b0, 1'b1);
    @(posedge clk); #1; phi_en = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("samecyc_overflow", {ov0, ov2, ov3}, 0);
    idle(4);
    chk("bp_sync_err", se0, 0);

    // Early frame_sync at slot 10: restart, stay locked
    send(9'h180, 9'h180, 1'b1);
    for (int i = 1; i < 10; i++) send(9'h180, 9'h180, 1'b0);
    frame(9'h0C0, 9'h100, 1'b0, 1'b1);
    idle(1);
    @(negedge clk);
    chk("restart_sync_err", se0, 1);
    chk("restart_locked", lk0, 1);
    idle(3);
    pulse_clr();
    @(negedge clk);
    chk("restart_clr", se0, 0);

    // Missing frame_sync at slot 0: unlock until next marker
    frame(9'h180, 9'h100, 1'b0, 1'b1);
    idle(2);
    send(9'h1FF, 9'h1FF, 1'b0);
    @(posedge clk); #1; phi_en = 1'b0;
    @(negedge clk);
    chk("unlock_sync_err", se0, 1);
    chk("unlock_locked", lk0, 0);
    for (int i = 0; i < 5; i++) send(9'h1FF, 9'h1FF, 1'b0);
    idle(1);
    chk("unlock_stays", {lk0, lk2, lk3}, 0);
    frame(9'h0C0, 9'h0C0, 1'b0, 1'b1);
    idle(3);
    chk("relock", lk0, 1);
    pulse_clr();

    // Mid-frame reset with a held word and a set flag
    out_ready = 1'b0;
    frame(9'h1FF, 9'h000, 1'b0, 1'b1);
    idle(3);
    for (int i = 0; i < 12; i++) send(9'h1FF, 9'h1FF, (i == 0 || i == 5));
    @(negedge clk);
    chk("pre_rst_valid", v0, 1);
    chk("pre_rst_head", l0, 6120);
    chk("pre_rst_sync_err", se0, 1);
    @(posedge clk); #1;
    rst = 1'b1; phi_en = 1'b1; frame_sync = 1'b0;
    q0.delete(); q2.delete(); q3.delete();
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check_reset("midrst");
    for (int i = 13; i < 24; i++) send(9'h1FF, 9'h1FF, 1'b0);
    out_ready = 1'b1;
    idle(5);
    @(negedge clk);
    chk("midrst_no_word", v0, 0);
    chk("midrst_unlocked", lk0, 0);

    idle(5);
    chk("q0_drained", q0.size(), 0);
    chk("q2_drained", q2.size(), 0);
    chk("q3_drained", q3.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
